// File: rtl/cordic_atan_seq.sv
// cordic_atan_seq
// Steps an iterative CORDIC rotation stage through micro-rotation indices
// 0..N-1. Each index is presented as one registered tuple: the index, the
// rounded atan(2^-i) in degrees, the x/y shift amount and a last flag.
//
// Parameters
//   INT_W  : integer bits of the unsigned angle (>= 6 so atan(1)=45 fits)
//   FRAC_W : fraction bits of the angle, 1..16
//   ITER   : maximum iteration count, 1..16
//
// Ports
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : begin a sequence (sampled only while idle)
//   cfg_iters  : requested count, latched when start is accepted
//                (0 runs one step, values above ITER run ITER steps)
//   abort      : synchronous cancel; beats start and handshake completion
//   busy       : FSM is not idle (the FSM has two states, so this is its
//                complete state view)
//   out_*      : tuple stream, done pulses once after the last acceptance
//
// Handshake: a tuple moves on every rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low all
// tuple fields hold. out_valid, out_last and done are registers, so there is
// no combinational path from out_ready to any output.
module cordic_atan_seq #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 8,
  parameter int ITER   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4:0]              cfg_iters,
  input  logic                    abort,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_iter,
  output logic [INT_W+FRAC_W-1:0] out_angle,
  output logic [3:0]              out_shift,
  output logic                    out_last,
  output logic                    done
);

  localparam int AW = INT_W + FRAC_W;
  localparam int DSH = 16 - FRAC_W;
  // Half an output LSB in the 16-fraction-bit table domain; collapses to 0
  // when FRAC_W = 16 so the table passes through unshifted.
  localparam logic [31:0] RND = (32'd1 << 15) >> FRAC_W;
  localparam logic [4:0] ITER_N = 5'(ITER);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t         state_q, state_n;
  logic [4:0]     n_q, n_n;
  logic           valid_q, valid_n;
  logic [3:0]     iter_q, iter_n;
  logic [AW-1:0]  angle_q, angle_n;
  logic           last_q, last_n;
  logic           done_q, done_n;
  logic [4:0]     n_clamp;
  logic [3:0]     iter_inc;

  // round(atan(2^-i) * 65536) degrees, then round half up to FRAC_W bits.
  function automatic logic [AW-1:0] angle_of(input logic [3:0] i);
    logic [31:0] k;
    case (i)
      4'd0:    k = 32'd2949120;
      4'd1:    k = 32'd1740967;
      4'd2:    k = 32'd919879;
      4'd3:    k = 32'd466945;
      4'd4:    k = 32'd234379;
      4'd5:    k = 32'd117304;
      4'd6:    k = 32'd58666;
      4'd7:    k = 32'd29335;
      4'd8:    k = 32'd14668;
      4'd9:    k = 32'd7334;
      4'd10:   k = 32'd3667;
      4'd11:   k = 32'd1833;
      4'd12:   k = 32'd917;
      4'd13:   k = 32'd458;
      4'd14:   k = 32'd229;
      default: k = 32'd115;
    endcase
    return AW'((k + RND) >> DSH);
  endfunction

  always_comb begin
    state_n  = state_q;
    n_n      = n_q;
    valid_n  = valid_q;
    iter_n   = iter_q;
    angle_n  = angle_q;
    last_n   = last_q;
    done_n   = 1'b0;
    iter_inc = iter_q + 4'd1;

    if (cfg_iters == 5'd0)        n_clamp = 5'd1;
    else if (cfg_iters > ITER_N)  n_clamp = ITER_N;
    else                          n_clamp = cfg_iters;

    if (abort) begin
      state_n = S_IDLE;
      valid_n = 1'b0;
      last_n  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_n = S_RUN;
            n_n     = n_clamp;
            valid_n = 1'b1;
            iter_n  = 4'd0;
            angle_n = angle_of(4'd0);
            last_n  = (n_clamp == 5'd1);
          end
        end
        S_RUN: begin
          if (valid_q && out_ready) begin
            if (last_q) begin
              state_n = S_IDLE;
              valid_n = 1'b0;
              last_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              // Next index is loaded on the accepting edge: no bubbles.
              iter_n  = iter_inc;
              angle_n = angle_of(iter_inc);
              last_n  = ({1'b0, iter_inc} == (n_q - 5'd1));
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= 5'd1;
      valid_q <= 1'b0;
      iter_q  <= 4'd0;
      angle_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      n_q     <= n_n;
      valid_q <= valid_n;
      iter_q  <= iter_n;
      angle_q <= angle_n;
      last_q  <= last_n;
      done_q  <= done_n;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = valid_q;
  assign out_iter  = iter_q;
  assign out_shift = iter_q;
  assign out_angle = angle_q;
  assign out_last  = last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cordic_atan_seq.sv
// Bench for cordic_atan_seq. Instance a uses default parameters
// (FRAC_W=8, ITER=16); instance b uses FRAC_W=4, ITER=8. Expected tuples
// are queued when a start is driven and compared on each accepted tuple.
module tb_cordic_atan_seq;

  localparam logic [15:0] REF8 [16] = '{
    16'h2D00, 16'h1A91, 16'h0E09, 16'h0720, 16'h0394, 16'h01CA, 16'h00E5, 16'h0073,
    16'h0039, 16'h001D, 16'h000E, 16'h0007, 16'h0004, 16'h0002, 16'h0001, 16'h0000};
  // round(atan(2^-i) degrees * 16), i = 0..7
  localparam logic [11:0] REF4 [8] = '{
    12'h2D0, 12'h1A9, 12'h0E1, 12'h072, 12'h039, 12'h01D, 12'h00E, 12'h007};

  logic clk, rst_n;

  logic        a_start, a_abort, a_ready;
  logic [4:0]  a_cfg;
  logic        a_busy, a_valid, a_last, a_done;
  logic [3:0]  a_iter, a_shift;
  logic [15:0] a_angle;

  logic        b_start, b_abort, b_ready;
  logic [4:0]  b_cfg;
  logic        b_busy, b_valid, b_last, b_done;
  logic [3:0]  b_iter, b_shift;
  logic [11:0] b_angle;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  int total = 0;
  int bad = 0;
  int a_acc = 0, a_done_cnt = 0;
  int b_acc = 0, b_done_cnt = 0;

  cordic_atan_seq u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .cfg_iters(a_cfg), .abort(a_abort),
    .busy(a_busy), .out_valid(a_valid), .out_ready(a_ready), .out_iter(a_iter),
    .out_angle(a_angle), .out_shift(a_shift), .out_last(a_last), .done(a_done));

  cordic_atan_seq #(.INT_W(8), .FRAC_W(4), .ITER(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .cfg_iters(b_cfg), .abort(b_abort),
    .busy(b_busy), .out_valid(b_valid), .out_ready(b_ready), .out_iter(b_iter),
    .out_angle(b_angle), .out_shift(b_shift), .out_last(b_last), .done(b_done));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: accepted tuples are popped and compared away from the edge
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && a_valid && a_ready) begin
      a_acc++;
      if (exp_a.size() == 0) check("a_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_a.pop_front();
        check("a_tuple", {7'd0, a_iter, a_shift, a_angle, a_last}, e);
      end
    end
    if (rst_n && b_valid && b_ready) begin
      b_acc++;
      if (exp_b.size() == 0) check("b_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_b.pop_front();
        check("b_tuple", {7'd0, b_iter, b_shift, 4'd0, b_angle, b_last}, e);
      end
    end
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampn(input int cfg, input int mx);
    if (cfg == 0) return 1;
    if (cfg > mx) return mx;
    return cfg;
  endfunction

  task automatic a_go(input int cfg);
    int n;
    n = clampn(cfg, 16);
    for (int i = 0; i < n; i++)
      exp_a.push_back({7'd0, 4'(i), 4'(i), REF8[i], 1'(i == n - 1)});
    a_cfg = 5'(cfg);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic b_go(input int cfg);
    int n;
    n = clampn(cfg, 8);
    for (int i = 0; i < n; i++)
      exp_b.push_back({7'd0, 4'(i), 4'(i), 4'd0, REF4[i], 1'(i == n - 1)});
    b_cfg = 5'(cfg);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string tag);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (sel ? b_done : a_done) begin
        hit = 1'b1;
        break;
      end
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int early, acc0, dc0;
    rst_n = 1'b0;
    a_start = 0; a_abort = 0; a_ready = 0; a_cfg = 0;
    b_start = 0; b_abort = 0; b_ready = 0; b_cfg = 0;

    // reset values
    repeat (3) tick();
    check("rst_a_outs", {a_busy, a_valid, a_iter, a_shift, a_angle, a_last, a_done}, 32'd0);
    check("rst_b_outs", {b_busy, b_valid, b_iter, b_shift, b_angle, b_last, b_done}, 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    check("idle_a_outs", {a_busy, a_valid, a_iter, a_angle, a_last, a_done}, 32'd0);
    check("idle_no_done", 32'(a_done_cnt + b_done_cnt), 32'd0);

    // full 16-step run, ready always high
    a_ready = 1'b1;
    a_go(16);
    check("full_first", {a_valid, a_iter, a_angle}, {1'b1, 4'd0, 16'h2D00});
    check("full_busy", 32'(a_busy), 32'd1);
    early = 0;
    repeat (15) begin
      tick();
      if (a_done) early++;
    end
    check("full_no_early_done", 32'(early), 32'd0);
    tick();
    check("full_done_k16", {a_done, a_valid, a_busy}, 3'b100);
    tick();
    check("full_done_pulse", 32'(a_done), 32'd0);
    check("full_q_empty", 32'(exp_a.size()), 32'd0);

    // backpressure while i=1 is presented
    acc0 = a_acc;
    a_go(4);
    tick();
    a_ready = 1'b0;
    repeat (3) begin
      tick();
      check("bp_hold", {a_valid, a_iter, a_shift, a_angle, a_last}, {1'b1, 4'd1, 4'd1, 16'h1A91, 1'b0});
    end
    a_ready = 1'b1;
    tick();
    check("bp_i2", {a_valid, a_iter}, {1'b1, 4'd2});
    tick();
    check("bp_i3", {a_valid, a_iter, a_last}, {1'b1, 4'd3, 1'b1});
    tick();
    check("bp_done", 32'(a_done), 32'd1);
    check("bp_count", 32'(a_acc - acc0), 32'd4);

    // abort while i=5 is stalled
    dc0 = a_done_cnt;
    a_go(10);
    repeat (5) tick();
    a_ready = 1'b0;
    tick();
    check("ab_stall", {a_valid, a_iter}, {1'b1, 4'd5});
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("ab_cleared", {a_valid, a_last, a_busy, a_done}, 4'b0000);
    check("ab_left", 32'(exp_a.size()), 32'd5);
    exp_a.delete();
    a_ready = 1'b1;
    a_go(3);
    check("ab_restart", {a_valid, a_iter, a_busy}, {1'b1, 4'd0, 1'b1});
    wait_done(1'b0, "ab_restart_done");
    check("ab_done_count", 32'(a_done_cnt - dc0), 32'd1);

    // start while busy is ignored
    acc0 = a_acc;
    a_go(6);
    repeat (3) tick();
    check("sb_at3", 32'(a_iter), 32'd3);
    a_cfg = 5'd2;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_done(1'b0, "sb_done");
    check("sb_count", 32'(a_acc - acc0), 32'd6);
    tick();
    check("sb_idle", {a_busy, a_valid}, 2'b00);

    // asynchronous reset mid-sequence, between clock edges
    a_go(8);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {a_busy, a_valid, a_iter, a_angle, a_last, a_done}, 32'd0);
    exp_a.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // narrow instance: clamp and precision
    b_ready = 1'b1;
    acc0 = b_acc;
    b_go(0);
    check("b_single", {b_valid, b_iter, b_angle, b_last}, {1'b1, 4'd0, 12'h2D0, 1'b1});
    wait_done(1'b1, "b_single_done");
    check("b_single_count", 32'(b_acc - acc0), 32'd1);
    // new start in the cycle done is high
    acc0 = b_acc;
    b_go(20);
    tick();
    check("b_i1_angle", {b_iter, b_angle}, {4'd1, 12'h1A9});
    wait_done(1'b1, "b_clamp_done");
    check("b_clamp_count", 32'(b_acc - acc0), 32'd8);

    tick();
    check("final_qa", 32'(exp_a.size()), 32'd0);
    check("final_qb", 32'(exp_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
